// File: rtl/config_cmd_decoder.sv
// Configuration command decoder: parses header/payload command words, drives field values with
// one-cycle write strobes, keeps shadow copies for readback and returns one response per frame.
module config_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCIE_dma_engine_clk,
  input  logic        rst,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  narrow_band_width,
  output logic        narrow_band_width_en,
  output logic [1:0]  filter_mode,
  output logic        filter_mode_en,
  output logic [7:0]  start_cmp_position,
  output logic        start_cmp_position_en,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  err_count
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPayload = 2'd1;
  localparam logic [1:0] StResp    = 2'd2;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  nbw_q, nbw_d;
  logic [1:0]  fm_q, fm_d;
  logic [7:0]  scp_q, scp_d;
  logic        nbw_en_q, nbw_en_d;
  logic        fm_en_q, fm_en_d;
  logic        scp_en_q, scp_en_d;
  logic [7:0]  err_q, err_d;
  logic        err_inc;
  logic        hs;
  logic [7:0]  rd_val;
  logic        rd_hit;
  logic [7:0]  wval;

  assign cmd_ready = ~rst & ((state_q == StIdle) | (state_q == StPayload));
  assign hs        = cmd_valid & cmd_ready;
  assign wval      = cmd_data[7:0];

  // Readback mux, addressed by the header currently on the command bus
  always_comb begin
    rd_val = 8'h00;
    rd_hit = 1'b1;
    case (cmd_data[15:8])
      8'h00:   rd_val = nbw_q;
      8'h01:   rd_val = {6'b0, fm_q};
      8'h02:   rd_val = scp_q;
      default: rd_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    nbw_d      = nbw_q;
    fm_d       = fm_q;
    scp_d      = scp_q;
    nbw_en_d   = 1'b0;
    fm_en_d    = 1'b0;
    scp_en_d   = 1'b0;
    err_inc    = 1'b0;
    case (state_q)
      StIdle: begin
        if (hs) begin
          if (cmd_data[31:24] != 8'hA5) begin
            err_inc = 1'b1;
          end else begin
            addr_d = cmd_data[15:8];
            tag_d  = cmd_data[7:0];
            tmo_d  = '0;
            case (cmd_data[23:16])
              8'h01: state_d = StPayload;
              8'h02: begin
                state_d = StResp;
                if (rd_hit) begin
                  rsp_data_d = {8'h5A, 8'h00, cmd_data[7:0], rd_val};
                end else begin
                  rsp_data_d = {8'h5A, 8'h01, cmd_data[7:0], 8'h00};
                  err_inc    = 1'b1;
                end
              end
              default: begin
                state_d    = StResp;
                rsp_data_d = {8'h5A, 8'h02, cmd_data[7:0], 8'h00};
                err_inc    = 1'b1;
              end
            endcase
          end
        end
      end
      StPayload: begin
        // A payload handshake in the last allowed cycle takes priority over the timeout
        if (hs) begin
          state_d    = StResp;
          rsp_data_d = {8'h5A, 8'h00, tag_q, wval};
          case (addr_q)
            8'h00: begin
              nbw_d    = wval;
              nbw_en_d = 1'b1;
            end
            8'h01: begin
              if (wval[7:2] == 6'd0) begin
                fm_d    = wval[1:0];
                fm_en_d = 1'b1;
              end else begin
                rsp_data_d = {8'h5A, 8'h04, tag_q, 8'h00};
                err_inc    = 1'b1;
              end
            end
            8'h02: begin
              scp_d    = wval;
              scp_en_d = 1'b1;
            end
            default: begin
              rsp_data_d = {8'h5A, 8'h01, tag_q, 8'h00};
              err_inc    = 1'b1;
            end
          endcase
        end else if (tmo_q == TmoLast) begin
          state_d    = StResp;
          rsp_data_d = {8'h5A, 8'h03, tag_q, 8'h00};
          err_inc    = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge PCIE_dma_engine_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= 8'h00;
      tag_q      <= 8'h00;
      tmo_q      <= 16'h0000;
      rsp_data_q <= 32'h0;
      nbw_q      <= 8'd25;
      fm_q       <= 2'd0;
      scp_q      <= 8'd0;
      nbw_en_q   <= 1'b0;
      fm_en_q    <= 1'b0;
      scp_en_q   <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      tmo_q      <= tmo_d;
      rsp_data_q <= rsp_data_d;
      nbw_q      <= nbw_d;
      fm_q       <= fm_d;
      scp_q      <= scp_d;
      nbw_en_q   <= nbw_en_d;
      fm_en_q    <= fm_en_d;
      scp_en_q   <= scp_en_d;
      err_q      <= err_d;
    end
  end

  assign narrow_band_width     = nbw_q;
  assign narrow_band_width_en  = nbw_en_q;
  assign filter_mode           = fm_q;
  assign filter_mode_en        = fm_en_q;
  assign start_cmp_position    = scp_q;
  assign start_cmp_position_en = scp_en_q;
  assign rsp_data              = rsp_data_q;
  assign rsp_valid             = (state_q == StResp);
  assign err_count             = err_q;

endmodule
